delta_bbox: RTL and testbench

Consumes the thresholded binary motion mask produced by the delta-frame stage and reduces each video frame to a single bounding box around all motion pixels. It counts raster position internally from the active-video qualifier, accumulates min/max X/Y and a motion-pixel count over one frame, and publishes the results once per frame with a one-cycle strobe. It sits between the delta-frame stage and the tracking/overlay logic.

---
 rtl/delta_bbox.sv | 228 ++++++++++++++++++++++
 tb/tb_delta_bbox.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/delta_bbox.sv
// delta_bbox: reduces a binary motion mask to one bounding box per frame.
// The raster position is tracked internally from the active-video qualifier.
// Min/max X/Y and a saturating hit count are accumulated over the frame, and
// the results are published once per frame with a one-cycle strobe.
module delta_bbox #(
    parameter int unsigned INPUT_WIDTH = 10,
    parameter int unsigned X_WIDTH     = 10,
    parameter int unsigned Y_WIDTH     = 10,
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned MIN_COUNT   = 16
) (
    input  logic                       clk,
    input  logic                       aresetn,
    input  logic                       frame_start,
    input  logic                       is_not_blank,
    input  logic [INPUT_WIDTH-1:0]     delta_frame,
    output logic [X_WIDTH-1:0]         box_x_min,
    output logic [X_WIDTH-1:0]         box_x_max,
    output logic [Y_WIDTH-1:0]         box_y_min,
    output logic [Y_WIDTH-1:0]         box_y_max,
    output logic [X_WIDTH+Y_WIDTH-1:0] pixel_count,
    output logic                       box_valid,
    output logic                       result_strobe,
    output logic                       frame_error
);

    localparam int unsigned CNT_WIDTH = X_WIDTH + Y_WIDTH;

    localparam logic [X_WIDTH-1:0]   X_LAST  = X_WIDTH'(H_ACTIVE - 1);
    localparam logic [Y_WIDTH-1:0]   Y_LAST  = Y_WIDTH'(V_ACTIVE - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MIN = CNT_WIDTH'(MIN_COUNT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCUM   = 2'd1,
        PUBLISH = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    // Raster position of the next active pixel
    logic [X_WIDTH-1:0]   x_pos;
    logic [Y_WIDTH-1:0]   y_pos;

    // Per-frame accumulators
    logic [X_WIDTH-1:0]   x_min_acc;
    logic [X_WIDTH-1:0]   x_max_acc;
    logic [Y_WIDTH-1:0]   y_min_acc;
    logic [Y_WIDTH-1:0]   y_max_acc;
    logic [CNT_WIDTH-1:0] count_acc;

    // Control decodes
    logic hit;
    logic frame_init;
    logic frame_abort;
    logic accept;
    logic accept_hit;
    logic at_line_end;
    logic at_frame_end;
    logic last_pixel;
    logic publish;
    logic count_valid;

    // Decode pixel acceptance, frame boundaries and the abort condition
    always_comb begin
        hit          = |delta_frame;
        frame_init   = frame_start;
        frame_abort  = (state == ACCUM) && frame_start;
        // A pixel sharing a cycle with frame_start belongs to the frame being
        // discarded (or to no frame at all), so it is never accepted.
        accept       = (state == ACCUM) && is_not_blank && !frame_start;
        accept_hit   = accept && hit;
        at_line_end  = (x_pos == X_LAST);
        at_frame_end = at_line_end && (y_pos == Y_LAST);
        last_pixel   = accept && at_frame_end;
        publish      = (state == PUBLISH);
        count_valid  = (count_acc >= CNT_MIN);
    end

    // State register
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (frame_start) begin
                    state_next = ACCUM;
                end
            end
            ACCUM: begin
                if (frame_start) begin
                    state_next = ACCUM;
                end else if (last_pixel) begin
                    state_next = PUBLISH;
                end
            end
            PUBLISH: begin
                if (frame_start) begin
                    state_next = ACCUM;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Raster counter: advances only on accepted pixels, wraps per line/frame
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            x_pos <= '0;
            y_pos <= '0;
        end else if (frame_init) begin
            x_pos <= '0;
            y_pos <= '0;
        end else if (accept) begin
            if (at_line_end) begin
                x_pos <= '0;
                if (y_pos == Y_LAST) begin
                    y_pos <= '0;
                end else begin
                    y_pos <= y_pos + 1'b1;
                end
            end else begin
                x_pos <= x_pos + 1'b1;
            end
        end
    end

    // Column bounds of the hits seen so far in this frame
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            x_min_acc <= '1;
            x_max_acc <= '0;
        end else if (frame_init) begin
            x_min_acc <= '1;
            x_max_acc <= '0;
        end else if (accept_hit) begin
            if (x_pos < x_min_acc) begin
                x_min_acc <= x_pos;
            end
            if (x_pos > x_max_acc) begin
                x_max_acc <= x_pos;
            end
        end
    end

    // Row bounds of the hits seen so far in this frame
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            y_min_acc <= '1;
            y_max_acc <= '0;
        end else if (frame_init) begin
            y_min_acc <= '1;
            y_max_acc <= '0;
        end else if (accept_hit) begin
            if (y_pos < y_min_acc) begin
                y_min_acc <= y_pos;
            end
            if (y_pos > y_max_acc) begin
                y_max_acc <= y_pos;
            end
        end
    end

    // Saturating hit counter
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            count_acc <= '0;
        end else if (frame_init) begin
            count_acc <= '0;
        end else if (accept_hit && (count_acc != '1)) begin
            count_acc <= count_acc + 1'b1;
        end
    end

    // Published results: latched in PUBLISH, held until the next publish.
    // A frame_start in PUBLISH reinitialises the accumulators on the same
    // edge, which is safe because these registers sample the old values.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            box_x_min   <= '0;
            box_x_max   <= '0;
            box_y_min   <= '0;
            box_y_max   <= '0;
            pixel_count <= '0;
            box_valid   <= 1'b0;
        end else if (publish) begin
            pixel_count <= count_acc;
            box_valid   <= count_valid;
            if (count_valid) begin
                box_x_min <= x_min_acc;
                box_x_max <= x_max_acc;
                box_y_min <= y_min_acc;
                box_y_max <= y_max_acc;
            end else begin
                box_x_min <= '0;
                box_x_max <= '0;
                box_y_min <= '0;
                box_y_max <= '0;
            end
        end
    end

    // One-cycle event pulses
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            result_strobe <= 1'b0;
            frame_error   <= 1'b0;
        end else begin
            result_strobe <= publish;
            frame_error   <= frame_abort;
        end
    end

endmodule

// File: tb/tb_delta_bbox.sv
// Directed testbench for delta_bbox on an 8x4 raster with MIN_COUNT=2.
module tb_delta_bbox;

    logic       clk;
    logic       aresetn;
    logic       frame_start;
    logic       is_not_blank;
    logic [9:0] delta_frame;
    logic [3:0] box_x_min;
    logic [3:0] box_x_max;
    logic [3:0] box_y_min;
    logic [3:0] box_y_max;
    logic [7:0] pixel_count;
    logic       box_valid;
    logic       result_strobe;
    logic       frame_error;

    int checks;
    int errors;
    int strobe_cnt;
    int error_cnt;

    delta_bbox #(
        .INPUT_WIDTH (10),
        .X_WIDTH     (4),
        .Y_WIDTH     (4),
        .H_ACTIVE    (8),
        .V_ACTIVE    (4),
        .MIN_COUNT   (2)
    ) dut (
        .clk           (clk),
        .aresetn       (aresetn),
        .frame_start   (frame_start),
        .is_not_blank  (is_not_blank),
        .delta_frame   (delta_frame),
        .box_x_min     (box_x_min),
        .box_x_max     (box_x_max),
        .box_y_min     (box_y_min),
        .box_y_max     (box_y_max),
        .pixel_count   (pixel_count),
        .box_valid     (box_valid),
        .result_strobe (result_strobe),
        .frame_error   (frame_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters sampled away from the active edge
    always @(negedge clk) begin
        if (result_strobe === 1'b1) strobe_cnt <= strobe_cnt + 1;
        if (frame_error === 1'b1) error_cnt <= error_cnt + 1;
    end

    // {x_min, x_max, y_min, y_max, count, valid}
    function automatic logic [24:0] outs();
        return {box_x_min, box_x_max, box_y_min, box_y_max, pixel_count, box_valid};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_frame_start();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
    endtask

    // Streams 32 active pixels; hit bit index is y*8+x. Blank gaps carry a
    // non-zero mask to show the qualifier gates it.
    task automatic stream(input logic [31:0] hits, input int gap);
        for (int y = 0; y < 4; y++) begin
            for (int x = 0; x < 8; x++) begin
                is_not_blank = 1'b1;
                delta_frame  = hits[y*8+x] ? 10'(1 << ((x + y) % 10)) : '0;
                step();
            end
            is_not_blank = 1'b0;
            delta_frame  = '1;
            if (y != 3) begin
                for (int g = 0; g < gap; g++) step();
            end
        end
        delta_frame = '0;
    endtask

    task automatic test_reset();
        aresetn      = 1'b0;
        frame_start  = 1'b0;
        is_not_blank = 1'b0;
        delta_frame  = '0;
        step();
        step();
        checks++;
        if (outs() !== 25'd0) begin
            errors++;
            $display("FAIL reset_outs got=%h exp=%h", outs(), 25'd0);
        end
        checks++;
        if ({result_strobe, frame_error} !== 2'b00) begin
            errors++;
            $display("FAIL reset_pulses got=%b exp=00", {result_strobe, frame_error});
        end
        aresetn = 1'b1;
        step();
    endtask

    task automatic test_two_hits();
        logic [24:0] exp_o;
        exp_o = {4'd2, 4'd5, 4'd1, 4'd3, 8'd2, 1'b1};
        pulse_frame_start();
        stream(32'h2000_0400, 0);
        checks++;
        if (result_strobe !== 1'b0) begin
            errors++;
            $display("FAIL two_hits_early_strobe got=%b exp=0", result_strobe);
        end
        step();
        checks++;
        if (result_strobe !== 1'b1) begin
            errors++;
            $display("FAIL two_hits_strobe got=%b exp=1", result_strobe);
        end
        checks++;
        if (outs() !== exp_o) begin
            errors++;
            $display("FAIL two_hits_outs got=%h exp=%h", outs(), exp_o);
        end
        step();
        checks++;
        if (result_strobe !== 1'b0) begin
            errors++;
            $display("FAIL two_hits_strobe_width got=%b exp=0", result_strobe);
        end
        step();
        checks++;
        if (outs() !== exp_o) begin
            errors++;
            $display("FAIL two_hits_hold got=%h exp=%h", outs(), exp_o);
        end
    endtask

    task automatic test_single_hit();
        logic [24:0] exp_o;
        exp_o = {4'd0, 4'd0, 4'd0, 4'd0, 8'd1, 1'b0};
        pulse_frame_start();
        stream(32'h0000_0080, 0);
        step();
        checks++;
        if (result_strobe !== 1'b1) begin
            errors++;
            $display("FAIL single_hit_strobe got=%b exp=1", result_strobe);
        end
        checks++;
        if (outs() !== exp_o) begin
            errors++;
            $display("FAIL single_hit_outs got=%h exp=%h", outs(), exp_o);
        end
        step();
    endtask

    task automatic test_blank_gaps();
        logic [24:0] exp_o;
        exp_o = {4'd0, 4'd7, 4'd0, 4'd3, 8'd32, 1'b1};
        pulse_frame_start();
        stream(32'hFFFF_FFFF, 3);
        checks++;
        if (result_strobe !== 1'b0) begin
            errors++;
            $display("FAIL gaps_early_strobe got=%b exp=0", result_strobe);
        end
        step();
        checks++;
        if (result_strobe !== 1'b1) begin
            errors++;
            $display("FAIL gaps_strobe got=%b exp=1", result_strobe);
        end
        checks++;
        if (outs() !== exp_o) begin
            errors++;
            $display("FAIL gaps_outs got=%h exp=%h", outs(), exp_o);
        end
        step();
    endtask

    task automatic test_early_frame_start();
        logic [24:0] prev_o;
        logic [24:0] exp_o;
        int          strobes_before;
        prev_o = {4'd0, 4'd7, 4'd0, 4'd3, 8'd32, 1'b1};
        exp_o  = {4'd4, 4'd4, 4'd2, 4'd3, 8'd2, 1'b1};
        strobes_before = strobe_cnt;
        pulse_frame_start();
        checks++;
        if (frame_error !== 1'b0) begin
            errors++;
            $display("FAIL early_first_start_err got=%b exp=0", frame_error);
        end
        for (int i = 0; i < 10; i++) begin
            is_not_blank = 1'b1;
            delta_frame  = '1;
            step();
        end
        // Duplicate start with a hit pixel in the same cycle: pixel dropped
        frame_start  = 1'b1;
        is_not_blank = 1'b1;
        delta_frame  = '1;
        step();
        frame_start  = 1'b0;
        is_not_blank = 1'b0;
        delta_frame  = '0;
        checks++;
        if (frame_error !== 1'b1) begin
            errors++;
            $display("FAIL early_error_pulse got=%b exp=1", frame_error);
        end
        step();
        checks++;
        if (frame_error !== 1'b0) begin
            errors++;
            $display("FAIL early_error_width got=%b exp=0", frame_error);
        end
        checks++;
        if (outs() !== prev_o) begin
            errors++;
            $display("FAIL early_outs_held got=%h exp=%h", outs(), prev_o);
        end
        checks++;
        if (strobe_cnt !== strobes_before) begin
            errors++;
            $display("FAIL early_no_strobe got=%0d exp=%0d", strobe_cnt, strobes_before);
        end
        stream(32'h1010_0000, 0);
        step();
        checks++;
        if (result_strobe !== 1'b1) begin
            errors++;
            $display("FAIL early_next_strobe got=%b exp=1", result_strobe);
        end
        checks++;
        if (outs() !== exp_o) begin
            errors++;
            $display("FAIL early_next_outs got=%h exp=%h", outs(), exp_o);
        end
        step();
    endtask

    task automatic test_reset_mid_frame();
        logic [24:0] exp_o;
        int          strobes_before;
        int          errs_before;
        exp_o = {4'd1, 4'd6, 4'd1, 4'd2, 8'd2, 1'b1};
        pulse_frame_start();
        for (int i = 0; i < 5; i++) begin
            is_not_blank = 1'b1;
            delta_frame  = '1;
            step();
        end
        is_not_blank = 1'b0;
        delta_frame  = '0;
        strobes_before = strobe_cnt;
        errs_before    = error_cnt;
        aresetn = 1'b0;
        #1;
        checks++;
        if (outs() !== 25'd0) begin
            errors++;
            $display("FAIL midreset_async_outs got=%h exp=%h", outs(), 25'd0);
        end
        step();
        aresetn = 1'b1;
        step();
        checks++;
        if ((strobe_cnt - strobes_before) !== 0 || (error_cnt - errs_before) !== 0) begin
            errors++;
            $display("FAIL midreset_pulses got=%0d/%0d exp=0/0",
                     strobe_cnt - strobes_before, error_cnt - errs_before);
        end
        // Pixels in IDLE must be ignored
        for (int i = 0; i < 5; i++) begin
            is_not_blank = 1'b1;
            delta_frame  = '1;
            step();
        end
        is_not_blank = 1'b0;
        delta_frame  = '0;
        pulse_frame_start();
        stream(32'h0040_0200, 0);
        checks++;
        if (result_strobe !== 1'b0) begin
            errors++;
            $display("FAIL midreset_early_strobe got=%b exp=0", result_strobe);
        end
        step();
        checks++;
        if (result_strobe !== 1'b1) begin
            errors++;
            $display("FAIL midreset_strobe got=%b exp=1", result_strobe);
        end
        checks++;
        if (outs() !== exp_o) begin
            errors++;
            $display("FAIL midreset_outs got=%h exp=%h", outs(), exp_o);
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic [24:0] exp_a;
        logic [24:0] exp_b;
        exp_a = {4'd0, 4'd3, 4'd0, 4'd2, 8'd2, 1'b1};
        exp_b = {4'd6, 4'd7, 4'd3, 4'd3, 8'd2, 1'b1};
        pulse_frame_start();
        stream(32'h0008_0001, 0);
        // frame_start lands in the PUBLISH cycle
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        checks++;
        if (result_strobe !== 1'b1) begin
            errors++;
            $display("FAIL b2b_first_strobe got=%b exp=1", result_strobe);
        end
        checks++;
        if (outs() !== exp_a) begin
            errors++;
            $display("FAIL b2b_first_outs got=%h exp=%h", outs(), exp_a);
        end
        checks++;
        if (frame_error !== 1'b0) begin
            errors++;
            $display("FAIL b2b_no_error got=%b exp=0", frame_error);
        end
        stream(32'hC000_0000, 0);
        checks++;
        if (result_strobe !== 1'b0) begin
            errors++;
            $display("FAIL b2b_early_strobe got=%b exp=0", result_strobe);
        end
        step();
        checks++;
        if (result_strobe !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second_strobe got=%b exp=1", result_strobe);
        end
        checks++;
        if (outs() !== exp_b) begin
            errors++;
            $display("FAIL b2b_second_outs got=%h exp=%h", outs(), exp_b);
        end
        step();
        step();
        checks++;
        if (error_cnt !== 1) begin
            errors++;
            $display("FAIL total_error_pulses got=%0d exp=1", error_cnt);
        end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        strobe_cnt = 0;
        error_cnt  = 0;
        test_reset();
        test_two_hits();
        test_single_hit();
        test_blank_gaps();
        test_early_frame_start();
        test_reset_mid_frame();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
